// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: fetches words from a combinational instruction memory into a small PC-tagged queue for decode.
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   o_imem_addr                word index to instruction memory (always the current PC)
//   i_imem_instr               instruction at o_imem_addr, same cycle
//   i_redirect_valid/_pc       one-cycle redirect: load PC, flush queue, clear fault
//   o_out_valid/_instr/_pc     queue head toward decode (instr/pc are 0 when empty)
//   i_out_ready                decode accepts the head this cycle
//   o_fault                    sticky: fetch blocked because PC >= IMEM_DEPTH
module instr_fetch_sequencer #(
  parameter int IMEM_DEPTH  = 128,
  parameter int RESET_PC    = 0,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_instr,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_out_valid,
  output logic [31:0] o_out_instr,
  output logic [31:0] o_out_pc,
  input  logic        i_out_ready,
  output logic        o_fault
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [31:0]   DEPTH_C = 32'(IMEM_DEPTH);
  localparam logic [31:0]   RST_PC  = 32'(RESET_PC);
  localparam logic [CW-1:0] QD_C    = CW'(QUEUE_DEPTH);
  typedef enum logic {ST_RUN, ST_FAULT} state_t;
  state_t        r_state, w_state_nxt;
  logic [31:0]   r_pc, w_pc_nxt;
  logic [PW-1:0] r_head, r_tail, w_head_nxt, w_tail_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [31:0]   r_q_instr [QUEUE_DEPTH];
  logic [31:0]   r_q_pc    [QUEUE_DEPTH];
  logic          w_pop, w_fetch, w_in_range, w_room;
  assign o_imem_addr = r_pc;
  assign o_out_valid = r_count != '0;
  assign o_out_instr = o_out_valid ? r_q_instr[r_head] : '0;
  assign o_out_pc    = o_out_valid ? r_q_pc[r_head] : '0;
  assign o_fault     = r_state == ST_FAULT;
  // A full queue still accepts a fetch when the head leaves in the same cycle.
  always_comb begin
    w_pop       = o_out_valid && i_out_ready;
    w_in_range  = r_pc < DEPTH_C;
    w_room      = (r_count < QD_C) || w_pop;
    w_fetch     = (r_state == ST_RUN) && !i_redirect_valid && w_in_range && w_room;
    w_state_nxt = i_redirect_valid ? ST_RUN :
                  (r_state == ST_RUN && !w_in_range) ? ST_FAULT : r_state;
    w_pc_nxt    = i_redirect_valid ? i_redirect_pc : w_fetch ? r_pc + 32'd1 : r_pc;
    w_head_nxt  = i_redirect_valid ? '0 : w_pop ? r_head + PW'(1) : r_head;
    w_tail_nxt  = i_redirect_valid ? '0 : w_fetch ? r_tail + PW'(1) : r_tail;
    w_count_nxt = i_redirect_valid ? '0 :
                  (w_fetch && !w_pop) ? r_count + CW'(1) :
                  (w_pop && !w_fetch) ? r_count - CW'(1) : r_count;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_RUN;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc    <= RST_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
    end
  end
  // Queue storage needs no reset: entries are only visible while counted.
  always_ff @(posedge i_clk) begin
    if (w_fetch) begin
      r_q_instr[r_tail] <= i_imem_instr;
      r_q_pc[r_tail]    <= r_pc;
    end
  end
endmodule
